// File: rtl/luces_pkg.sv
// Shared types and helpers for the luces_fader lamp cross-fader.
package luces_pkg;

    typedef enum logic [1:0] {
        StOff     = 2'd0,
        StRising  = 2'd1,
        StOn      = 2'd2,
        StFalling = 2'd3
    } fade_state_t;

    function automatic int unsigned lvl_max(input int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

endpackage

// File: rtl/luces_fader_ch.sv
// One lamp channel: fade FSM, brightness level, duty mapping and PWM output register.
// Build option LUCES_FADER_GAMMA_EN selects square-law duty instead of linear.
module luces_fader_ch
    import luces_pkg::*;
#(
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned STEP     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic                i_tick,
    input  logic [PWM_BITS-1:0] i_pwm_cnt,
    output logic                o_pwm,
    output logic                o_active
);

    localparam logic [PWM_BITS:0] LVL_MAX_X = (PWM_BITS + 1)'(lvl_max(PWM_BITS));
    localparam logic [PWM_BITS:0] STEP_X    = (PWM_BITS + 1)'(STEP);

    fade_state_t         r_state;
    fade_state_t         w_state_d;
    logic [PWM_BITS-1:0] r_level;
    logic [PWM_BITS-1:0] w_level_d;
    logic [PWM_BITS-1:0] w_duty;
    logic [PWM_BITS:0]   w_up;
    logic [PWM_BITS:0]   w_dn;
    logic                r_pwm;
    logic                w_pwm_d;

    // One extra bit so saturation is detected instead of wrapping
    assign w_up = {1'b0, r_level} + STEP_X;
    assign w_dn = {1'b0, r_level} - STEP_X;

`ifdef LUCES_FADER_GAMMA_EN
    logic [2*PWM_BITS-1:0] w_lvl_x;
    logic [2*PWM_BITS-1:0] w_sq;
    assign w_lvl_x = {{PWM_BITS{1'b0}}, r_level};
    assign w_sq    = w_lvl_x * w_lvl_x;
    assign w_duty  = w_sq[2*PWM_BITS-1:PWM_BITS];
`else
    assign w_duty = r_level;
`endif

    always_comb begin
        w_state_d = r_state;
        w_level_d = r_level;
        unique case (r_state)
            StOff: begin
                if (i_req) w_state_d = StRising;
            end
            StRising: begin
                // Direction change takes priority over a coincident ramp tick
                if (!i_req) begin
                    w_state_d = StFalling;
                end else if (i_tick) begin
                    if (w_up >= LVL_MAX_X) begin
                        w_level_d = LVL_MAX_X[PWM_BITS-1:0];
                        w_state_d = StOn;
                    end else begin
                        w_level_d = w_up[PWM_BITS-1:0];
                    end
                end
            end
            StOn: begin
                if (!i_req) w_state_d = StFalling;
            end
            StFalling: begin
                if (i_req) begin
                    w_state_d = StRising;
                end else if (i_tick) begin
                    if (w_dn[PWM_BITS] || (w_dn == '0)) begin
                        w_level_d = '0;
                        w_state_d = StOff;
                    end else begin
                        w_level_d = w_dn[PWM_BITS-1:0];
                    end
                end
            end
            default: begin
                w_state_d = StOff;
            end
        endcase
    end

    always_comb begin
        w_pwm_d = 1'b0;
        unique case (r_state)
            StOff:   w_pwm_d = 1'b0;
            StOn:    w_pwm_d = 1'b1;
            default: w_pwm_d = (i_pwm_cnt < w_duty);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StOff;
            r_level <= '0;
            r_pwm   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_level <= w_level_d;
            r_pwm   <= w_pwm_d;
        end
    end

    assign o_pwm    = r_pwm;
    assign o_active = (r_state == StRising) || (r_state == StFalling);

endmodule

// File: rtl/luces_fader.sv
// Cross-fading PWM lamp driver behind the one-hot sequencer; one channel per lamp.
// Build option LUCES_FADER_GAMMA_EN enables square-law duty in every channel.
module luces_fader
    import luces_pkg::*;
#(
    parameter int unsigned N_LAMPS  = 4,
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned RAMP_DIV = 1024,
    parameter int unsigned STEP     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_LAMPS-1:0] luces_in,
    output logic [N_LAMPS-1:0] pwm_out,
    output logic               busy
);

    localparam int unsigned DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    logic [N_LAMPS-1:0]  r_luces_q;
    logic [DIV_W-1:0]    r_div_cnt;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic                r_busy;
    logic                w_tick;
    logic [N_LAMPS-1:0]  w_active;

    assign w_tick = (r_div_cnt == DIV_W'(RAMP_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_luces_q <= '0;
            r_div_cnt <= '0;
            r_pwm_cnt <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_luces_q <= luces_in;
            r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
            r_busy    <= |w_active;
        end
    end

    for (genvar gi = 0; gi < N_LAMPS; gi++) begin : g_ch
        luces_fader_ch #(
            .PWM_BITS (PWM_BITS),
            .STEP     (STEP)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .i_req     (r_luces_q[gi]),
            .i_tick    (w_tick),
            .i_pwm_cnt (r_pwm_cnt),
            .o_pwm     (pwm_out[gi]),
            .o_active  (w_active[gi])
        );
    end

    assign busy = r_busy;

endmodule
